// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encoding and op-class helpers for the
// multiply/divide unit. The accumulate ops (7-10) are only classified as
// arithmetic when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Latency class: 1 selects the divide latency, 0 the multiply latency.
  function automatic logic mdu_is_long(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle run and commit to HI/LO.
  function automatic logic mdu_is_arith(input logic [3:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage issue bundle plus HI/LO/busy/stall returns of the MDU.
// master = pipeline side, slave = mdu_scheduler.
interface mdu_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b, d_is_md,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, d_is_md,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result generator.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only under MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] a_s64, b_s64, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, div_b_s, quot_s, rem_s;
  logic        [31:0] div_b_u, quot_u, rem_u;
  logic               div_zero, div_ovf;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  // Products, quotients and the op-selected result.
  always_comb begin
    a_s      = $signed(src_a);
    b_s      = $signed(src_b);
    a_s64    = {{32{src_a[31]}}, src_a};
    b_s64    = {{32{src_b[31]}}, src_b};
    prod_s   = a_s64 * b_s64;
    prod_u   = {32'd0, src_a} * {32'd0, src_b};

    // Divide by zero and the one signed overflow case are patched below;
    // the divisor is steered away from zero so the dividers never see it.
    div_zero = (src_b == 32'd0);
    div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    div_b_s  = div_zero ? 32'sd1 : b_s;
    div_b_u  = div_zero ? 32'd1 : src_b;
    if (div_ovf) begin
      quot_s = $signed(32'h8000_0000);
      rem_s  = 32'sd0;
    end else begin
      quot_s = a_s / div_b_s;
      rem_s  = a_s % div_b_s;
    end
    quot_u   = src_a / div_b_u;
    rem_u    = src_a % div_b_u;

    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = div_zero ? {src_a, 32'hFFFF_FFFF} : {rem_s, quot_s};
      MDU_DIVU:  result = div_zero ? {src_a, 32'hFFFF_FFFF} : {rem_u, quot_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = {hi, lo} + prod_s;
      MDU_MADDU: result = {hi, lo} + prod_u;
      MDU_MSUB:  result = {hi, lo} - prod_s;
      MDU_MSUBU: result = {hi, lo} - prod_u;
      default:   result = {hi, lo};
`else
      default:   result = 64'd0;
`endif
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multi-cycle multiply/divide controller owning HI/LO.
// Optional accumulate ops (codes 7-10) are enabled by defining MDU_MADD_EN.
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q;
  logic [63:0]      pending;
  logic [63:0]      arith_res;

  mdu_arith u_arith (
    .op     (bus.md_op),
    .src_a  (bus.src_a),
    .src_b  (bus.src_b),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res)
  );

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  // Hazard stall must react in the same cycle as the issue strobe.
  assign bus.stall = bus.d_is_md & (bus.start | busy_q);

  // Issue/run FSM: latch result at issue, count down, commit to HI/LO at the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pending <= 64'd0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        if (mdu_is_arith(bus.md_op)) begin
          pending <= arith_res;
          cnt     <= mdu_is_long(bus.md_op) ? DIV_LOAD : MULT_LOAD;
          busy_q  <= 1'b1;
          state   <= ST_RUN;
        end else if (bus.md_op == MDU_MTHI) begin
          hi_q <= bus.src_a;
        end else if (bus.md_op == MDU_MTLO) begin
          lo_q <= bus.src_a;
        end
      end
    end else begin
      // A start seen here is an illegal overlap and is ignored.
      if (cnt == CNT_ONE) begin
        {hi_q, lo_q} <= pending;
        busy_q       <= 1'b0;
        cnt          <= '0;
        state        <= ST_IDLE;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: directed + randomized bench for mdu_scheduler against
// an arithmetic reference model of HI/LO and busy timing.
module tb_mdu_scheduler;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_hi, m_lo;

  mdu_if bus ();

  mdu_scheduler #(
    .MULT_CYCLES (MULT_CYC),
    .DIV_CYCLES  (DIV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // True for ops that run for a latency and commit a 64-bit result.
  function automatic bit is_run(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= 4'd7 && op <= 4'd10) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (!is_run(op)) return 0;
    return (op == 4'd3 || op == 4'd4) ? DIV_CYC : MULT_CYC;
  endfunction

  // Reference {hi,lo} after the op, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, qu, ru;
    logic [63:0]     q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        q64 = q; r64 = r;
        return {r64[31:0], q64[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        qu = ua / ub; ru = ua % ub;
        q64 = qu; r64 = ru;
        return {r64[31:0], q64[31:0]};
      end
      4'd5: return {a, acc[31:0]};
      4'd6: return {acc[63:32], a};
`ifdef MDU_MADD_EN
      4'd7:  return acc + sa * sb;
      4'd8:  return acc + ua * ub;
      4'd9:  return acc - sa * sb;
      4'd10: return acc - ua * ub;
`endif
      default: return acc;
    endcase
  endfunction

  // Issue one op and check busy/stall/HI/LO every cycle until it settles.
  // mid: busy cycle index at which an illegal extra start is driven (0 = none).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit force_md, input int mid);
    logic [63:0] old_v, new_v;
    int          n;
    bit          extra, exp_busy, md;
    old_v = {m_hi, m_lo};
    new_v = ref_result(op, a, b, old_v);
    n     = latency(op);
    @(negedge clk);
    md          = force_md ? 1'b1 : 1'($urandom_range(0, 1));
    bus.start   = 1'b1;
    bus.md_op   = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.d_is_md = md;
    #1;
    chk("stall_issue", {63'd0, bus.stall}, {63'd0, md});
    chk("busy_pre", {63'd0, bus.busy}, 64'd0);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      extra       = (k == mid) && (k <= n);
      bus.start   = extra;
      bus.md_op   = 4'($urandom_range(0, 15));
      bus.src_a   = $urandom;
      bus.src_b   = $urandom;
      md          = 1'($urandom_range(0, 1));
      bus.d_is_md = md;
      #1;
      exp_busy = (k <= n);
      chk("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
      chk("stall", {63'd0, bus.stall}, {63'd0, md & (extra | exp_busy)});
      chk("hilo", {bus.hi, bus.lo}, exp_busy ? old_v : new_v);
    end
    bus.start = 1'b0;
    m_hi = new_v[63:32];
    m_lo = new_v[31:0];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    total       = 0;
    bad         = 0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.md_op   = 4'd0;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    chk("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4'd4, 32'd100, 32'd7, 1'b0, 0);
    chk("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd3, 32'd1234, 32'd0, 1'b0, 0);
    chk("div0_const", {bus.hi, bus.lo}, {32'd1234, 32'hFFFF_FFFF});
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("div_ovf_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
    run_op(4'd5, 32'h0000_DEAD, 32'd0, 1'b1, 0);
    chk("mthi_const", {32'd0, bus.hi}, 64'h0000_DEAD);

    // Accumulate ops: behaviour depends on MDU_MADD_EN via the model.
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 0);
    run_op(4'd6, 32'd10, 32'd0, 1'b0, 0);
    run_op(4'd7, 32'd3, 32'd4, 1'b0, 0);
    run_op(4'd10, 32'd5, 32'd5, 1'b0, 0);

    // Extra start mid-run must be ignored.
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 2);

    // Async reset mid-run aborts with no commit.
    run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, 0);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.md_op   = 4'd2;
    bus.src_a   = 32'd9;
    bus.src_b   = 32'd9;
    bus.d_is_md = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("rst_run_stall", {63'd0, bus.stall}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_no_commit", {bus.hi, bus.lo}, 64'd0);

    // Randomized ops, including reserved codes and illegal overlaps.
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'b0, int'($urandom_range(0, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multi-cycle multiply/divide controller for the five-stage pipeline. Accepts one MDU operation per issue from the E stage and holds it busy for a fixed latency. Owns the HI/LO registers and raises the D-stage stall for any MDU-class instruction while an operation is in flight. Sits beside the ALU in E; the hazard unit ORs `stall` into its global stall.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD-family when enabled); legal range ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  E-stage issue strobe, sampled each rising edge.
- `md_op`  in  4  operation code (`mdu_pkg`), valid with `start`.
- `src_a`  in  32  rs value, forwarded (E_regA).
- `src_b`  in  32  rt value, forwarded (E_regB).
- `d_is_md`  in  1  D-stage instruction is MULT/DIV/MTHI/MTLO/MFHI/MFLO/MADD-family.
- `busy`  out  1  operation in flight.
- `stall`  out  1  combinational: `d_is_md & (start | busy)`.
- `hi`  out  32  HI register (MFHI source).
- `lo`  out  32  LO register (MFLO source).

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 reserved, treated as NONE.
- FSM: IDLE, RUN.
- IDLE + `start` + MULT/MULTU/DIV/DIVU (or MADD-family when enabled): compute result from `src_a`/`src_b` (and current {hi,lo} for MADD-family) into pending regs; load counter with latency; go RUN.
- IDLE + `start` + MTHI/MTLO: write `hi`/`lo` ← `src_a` at that edge; stay IDLE; `busy` stays low.
- RUN: decrement counter each cycle; at count==1 commit pending to {hi,lo}, go IDLE.
- `start` while RUN: ignored, no state change (pipeline stall guarantees this cannot occur legally).
- MULT: {hi,lo} = signed 32×32 → 64 product. MULTU: unsigned.
- DIV: lo = quotient truncated toward zero, hi = remainder with dividend sign. DIVU: unsigned.
- Divide by zero: hi ← `src_a`, lo ← 32'hFFFF_FFFF; normal latency.
- DIV 32'h8000_0000 / -1: lo = 32'h8000_0000, hi = 0.
- MADD/MADDU: {hi,lo} += product (signed/unsigned product); MSUB/MSUBU: {hi,lo} -= product; 64-bit wrap, no saturation. Base {hi,lo} sampled at issue.
- NONE/reserved with `start`: no effect.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, FSM=IDLE, pending=0. Asserting `reset` mid-RUN aborts; no commit.
- Issue at edge T: `busy` high in cycles T+1…T+N (N = MULT_CYCLES or DIV_CYCLES); new {hi,lo} and `busy`=0 visible from T+N+1.
- Back-to-back: a second op may issue at the edge where `busy` is low again (T+N+1 edge).
- MTHI/MTLO: value visible cycle after issue edge, zero busy cycles.
- `stall` is combinational from `start`, `busy`, `d_is_md`; no registered path.
- `hi`/`lo` only change at issue (MT*) or commit edge; stable otherwise.

## Configuration
- `MDU_MADD_EN` defined: op codes 7–10 implemented as above, using MULT_CYCLES latency.
- Not defined: op codes 7–10 treated as NONE (no busy, no HI/LO change); accumulate datapath not synthesized.

## Structure
- `mdu_pkg`: op-code localparams (`MDU_NONE`…`MDU_MSUBU`), FSM state encoding, helper `mdu_is_long(op)` returning latency class.
- One sub-module `mdu_arith`: combinational 64-bit result generator from op, `src_a`, `src_b`, current {hi,lo}; scheduler holds only FSM, counter, pending and HI/LO regs.

## Test plan
- MULT src_a=-3 (FFFF_FFFD), src_b=7 → `busy` high 5 cycles; then hi=FFFF_FFFF, lo=FFFF_FFEB.
- DIVU src_a=100, src_b=7 → `busy` 10 cycles; lo=14, hi=2; DIV -7/2 → lo=FFFF_FFFD, hi=FFFF_FFFF.
- DIV by zero, src_a=1234 → hi=1234, lo=FFFF_FFFF after 10 cycles; DIV 8000_0000/FFFF_FFFF → lo=8000_0000, hi=0.
- MTHI 0xDEAD issued then `d_is_md`=1 same cycle → `stall`=1 that cycle only; hi=0xDEAD next cycle, `busy` never high.
- MULTU in flight, `d_is_md`=1 (MFLO) → `stall` high through final busy cycle; extra `start` mid-RUN ignored; `reset` low at cycle 3 → hi=lo=0, `busy`=0 immediately.
- With `MDU_MADD_EN`: hi=0, lo=10, MADD 3×4 → lo=22 after 5 cycles; MSUBU 5×5 → {hi,lo}=FFFF_FFFF_FFFF_FFFD; without macro same op leaves {hi,lo}=0/10, `busy`=0.
